// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul sequencer and its datapath: FSM states and
// the lane/pipeline geometry the ROMs and multipliers are built around.
package matmul_pkg;

    localparam int LANES    = 16;
    localparam int PIPE_LAT = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/counter.sv
// Generic up-counter with synchronous clear; clear takes priority over enable.
module counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_l,
    input  logic             clear,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/valid_pipe.sv
// Fixed-depth valid shift register matching the ROM + operand-register latency,
// with a synchronous flush that drops every beat still in flight.
module valid_pipe #(
    parameter int DEPTH = matmul_pkg::PIPE_LAT
) (
    input  logic clock,
    input  logic reset_l,
    input  logic flush,
    input  logic valid,
    output logic delayed
);

    logic [DEPTH-1:0] stage;

    // NOTE: every stage is reset, because a stale valid here would fire acc_en after reset.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            stage <= '0;
        end else if (flush) begin
            stage <= '0;
        end else begin
            stage[0] <= valid;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign delayed = stage[DEPTH-1];

endmodule

// File: rtl/matmul_sequencer.sv
// Dot-product run sequencer: issues NUM_BEATS A/B ROM beat addresses, then drains
// the product pipeline and reports completion with a saturating cycle count.
module matmul_sequencer
    import matmul_pkg::state_t, matmul_pkg::IDLE, matmul_pkg::RUN,
           matmul_pkg::DRAIN, matmul_pkg::DONE;
#(
    parameter int LANES     = matmul_pkg::LANES,
    parameter int NUM_BEATS = 256,
    parameter int B_BEATS   = 4,
    parameter int PIPE_LAT  = matmul_pkg::PIPE_LAT
) (
    input  logic        clock,
    input  logic        reset_l,
    input  logic        start,
    input  logic        abort,
    output logic [12:0] romA_addr,
    output logic [5:0]  romB_addr,
    output logic        issue,
    output logic        acc_clear,
    output logic        acc_en,
    output logic        busy,
    output logic        done,
    output logic [15:0] cycle_count
);

    localparam int BEAT_W  = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    state_t              state;
    state_t              state_next;
    logic [BEAT_W-1:0]   beat;
    logic [DRAIN_W-1:0]  drain_idx;
    logic                draining;
    logic                accept;
    logic                flush;

    assign draining = (state == DRAIN);
    assign accept   = start && (state == IDLE || state == DONE);
    assign flush    = abort && busy;

    // Beat and drain indices are held at zero outside their own state.
    counter #(.WIDTH(BEAT_W)) u_beat (
        .clock   (clock),
        .reset_l (reset_l),
        .clear   (!issue),
        .en      (issue),
        .count   (beat)
    );

    counter #(.WIDTH(DRAIN_W)) u_drain (
        .clock   (clock),
        .reset_l (reset_l),
        .clear   (!draining),
        .en      (draining),
        .count   (drain_idx)
    );

    valid_pipe #(.DEPTH(PIPE_LAT)) u_valid_pipe (
        .clock   (clock),
        .reset_l (reset_l),
        .flush   (flush),
        .valid   (issue),
        .delayed (acc_en)
    );

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        acc_clear  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                issue     = 1'b1;
                busy      = 1'b1;
                acc_clear = (beat == '0);
                if (abort) begin
                    state_next = IDLE;
                end else if (beat == BEAT_W'(NUM_BEATS - 1)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (abort) begin
                    state_next = IDLE;
                end else if (drain_idx == DRAIN_W'(PIPE_LAT - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    // Addresses wrap silently at the port width; they read zero whenever no beat is issued.
    assign romA_addr = issue ? 13'(32'(beat) * 32'(LANES)) : '0;
    assign romB_addr = issue ? 6'((32'(beat) % 32'(B_BEATS)) * 32'(LANES)) : '0;

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            cycle_count <= '0;
        end else if (accept) begin
            cycle_count <= '0;
        end else if (busy && cycle_count != 16'hFFFF) begin
            cycle_count <= cycle_count + 16'd1;
        end
    end

endmodule
